// File: rtl/fir3x_drain.sv
// Output stage behind the 3x-unrolled FIR. It tags valid blocks, buffers triplets in a block FIFO and
// serializes them one sample per cycle. The optional output scaling is enabled by FIR3X_DRAIN_SCALE_EN.
module fir3x_drain #(
    parameter int LATENCY = 6,
    parameter int DEPTH   = 4,
    parameter int SHIFT   = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               src_valid,
    input  logic signed [31:0] y3k,
    input  logic signed [31:0] y3k1,
    input  logic signed [31:0] y3k2,
    output logic signed [31:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    typedef struct packed {
        logic signed [31:0] s0;
        logic signed [31:0] s1;
        logic signed [31:0] s2;
    } block_t;

    typedef enum logic [1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2
    } lane_e;

    if (LATENCY < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SHIFT < 1 || SHIFT > 31) begin : g_param_check
        $error("fir3x_drain: illegal LATENCY, DEPTH or SHIFT");
    end

    logic [LATENCY-1:0] r_tag;
    logic [AW:0]        r_wr;
    logic [AW:0]        r_rd;
    block_t             r_mem [DEPTH];
    lane_e              r_lane;
    lane_e              w_lane_nxt;
    logic               r_overflow;

    logic               w_tag;
    logic               w_empty;
    logic               w_full;
    logic               w_hs;
    logic               w_pop;
    logic               w_push;
    block_t             w_head;
    logic signed [31:0] w_sample;

    assign w_tag   = r_tag[LATENCY-1];
    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_hs    = out_valid && out_ready;
    assign w_pop   = w_hs && (r_lane == LANE2);
    // A pop on the same edge frees the slot the incoming block lands in.
    assign w_push  = w_tag && (!w_full || w_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag      <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_lane     <= LANE0;
            r_overflow <= 1'b0;
        end else begin
            r_tag  <= (r_tag << 1) | LATENCY'(src_valid);
            r_lane <= w_lane_nxt;
            if (w_push) r_wr <= r_wr + PTR_ONE;
            if (w_pop)  r_rd <= r_rd + PTR_ONE;
            if (w_tag && !w_push) r_overflow <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (!reset && w_push) r_mem[r_wr[AW-1:0]] <= '{s0: y3k, s1: y3k1, s2: y3k2};
    end

    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        w_lane_nxt = r_lane;
        if (w_hs) begin
            case (r_lane)
                LANE0:   w_lane_nxt = LANE1;
                LANE1:   w_lane_nxt = LANE2;
                default: w_lane_nxt = LANE0;
            endcase
        end
    end

    assign w_head = r_mem[r_rd[AW-1:0]];

    always_comb begin
        w_sample = w_head.s2;
        case (r_lane)
            LANE0:   w_sample = w_head.s0;
            LANE1:   w_sample = w_head.s1;
            default: w_sample = w_head.s2;
        endcase
    end

`ifdef FIR3X_DRAIN_SCALE_EN
    // Round half up in 33 bits, arithmetic shift, then clamp to the 16-bit range.
    function automatic logic signed [31:0] scale(input logic signed [31:0] y);
        logic signed [32:0] sum;
        logic signed [32:0] q;
        sum = {y[31], y} + (33'sd1 <<< (SHIFT - 1));
        q   = sum >>> SHIFT;
        if (q > 33'sd32767)
            return 32'sd32767;
        else if (q < -33'sd32768)
            return -32'sd32768;
        else
            return q[31:0];
    endfunction

    assign out_data = w_empty ? '0 : scale(w_sample);
`else
    assign out_data = w_empty ? '0 : w_sample;
`endif

    assign out_valid = !w_empty;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_fir3x_drain.sv
// Directed bench for fir3x_drain: table of single-block vectors plus hand-timed
// overflow, full-with-pop and reset-mid-drain sequences.
module tb_fir3x_drain;

    localparam int L = 6;
`ifdef FIR3X_DRAIN_SCALE_EN
    localparam int SM = 2048;
`else
    localparam int SM = 1;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               src_valid;
    logic signed [31:0] y3k, y3k1, y3k2;
    logic signed [31:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               overflow;

    int n_pass  = 0;
    int n_total = 0;

    fir3x_drain #(.LATENCY(L), .DEPTH(4), .SHIFT(11)) dut (
        .clk       (clk),
        .reset     (reset),
        .src_valid (src_valid),
        .y3k       (y3k),
        .y3k1      (y3k1),
        .y3k2      (y3k2),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] y0, y1, y2;
        logic [31:0] e0, e1, e2;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected sample for block k, lane j; the driven value is this times SM.
    function automatic logic [31:0] bv(input int k, input int j);
        return 32'(100 * k + 10 * j + 1);
    endfunction

    task automatic drive_blk(input int k);
        y3k  = 32'((100 * k + 1) * SM);
        y3k1 = 32'((100 * k + 11) * SM);
        y3k2 = 32'((100 * k + 21) * SM);
    endtask

    task automatic drive_junk();
        y3k  = 32'h0BAD_0001;
        y3k1 = 32'h0BAD_0002;
        y3k2 = 32'h0BAD_0003;
    endtask

    task automatic reset_pulse();
        reset = 1'b1; src_valid = 1'b0; out_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
`ifdef FIR3X_DRAIN_SCALE_EN
        vecs[0] = '{32'd100, 32'd200, 32'd300, 32'd0, 32'd0, 32'd0};
        vecs[1] = '{32'd2020000, 32'd1024, -32'sd1024, 32'd986, 32'd1, 32'd0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'd32767, 32'hFFFF_8000, 32'd0};
        vecs[3] = '{-32'sd3072, 32'd3072, 32'd2047, 32'hFFFF_FFFF, 32'd2, 32'd1};
`else
        vecs[0] = '{32'd100, 32'd200, 32'd300, 32'd100, 32'd200, 32'd300};
        vecs[1] = '{32'd2020000, 32'd1024, -32'sd1024, 32'd2020000, 32'd1024, 32'hFFFF_FC00};
        vecs[2] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0};
        vecs[3] = '{-32'sd3072, 32'd3072, 32'd2047, 32'hFFFF_F400, 32'd3072, 32'd2047};
`endif

        // Reset held two cycles with src_valid high; nothing may emerge afterwards.
        reset = 1'b1; src_valid = 1'b1; out_ready = 1'b1; drive_junk();
        step();
        step();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_data", out_data, 32'd0);
        reset = 1'b0; src_valid = 1'b0;
        for (int i = 0; i < L + 2; i++) begin
            step();
            check("rst_idle", {31'd0, out_valid}, 32'd0);
        end

        // Table: one block per vector, exact latency and three-sample drain.
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            src_valid = 1'b1;
            step();
            src_valid = 1'b0;
            for (int i = 1; i < L; i++) step();
            check("vec_pre_valid", {31'd0, out_valid}, 32'd0);
            y3k = vecs[v].y0; y3k1 = vecs[v].y1; y3k2 = vecs[v].y2;
            step();
            drive_junk();
            check("vec_valid0", {31'd0, out_valid}, 32'd1);
            check("vec_s0", out_data, vecs[v].e0);
            step();
            check("vec_s1", out_data, vecs[v].e1);
            step();
            check("vec_s2", out_data, vecs[v].e2);
            step();
            check("vec_done", {31'd0, out_valid}, 32'd0);
        end

        // Backpressure: five back-to-back blocks, the fifth is dropped.
        reset_pulse();
        for (int cyc = 0; cyc <= L + 5; cyc++) begin
            src_valid = (cyc < 5);
            if (cyc >= L && cyc < L + 5) drive_blk(cyc - L);
            else drive_junk();
            if (cyc == L + 4) check("ovf_before", {31'd0, overflow}, 32'd0);
            step();
        end
        src_valid = 1'b0;
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                check("ovf_drain", out_data, bv(k, j));
                step();
            end
        end
        check("ovf_empty", {31'd0, out_valid}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Full FIFO: a tagged block lands on the same edge as the lane-2 pop.
        reset_pulse();
        for (int cyc = 0; cyc <= L + 6; cyc++) begin
            src_valid = (cyc < 4) || (cyc == 6);
            if (cyc >= L && cyc < L + 4) drive_blk(cyc - L);
            else if (cyc == L + 6) drive_blk(4);
            else drive_junk();
            out_ready = (cyc >= L + 4);
            if (cyc == L + 6) check("fullpop_lane2", out_data, bv(0, 2));
            step();
        end
        src_valid = 1'b0; out_ready = 1'b0; drive_junk();
        check("fullpop_ovf", {31'd0, overflow}, 32'd0);
        check("fullpop_head", out_data, bv(1, 0));
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            for (int j = 0; j < 3; j++) begin
                check("fullpop_drain", out_data, bv(k, j));
                step();
            end
        end
        check("fullpop_empty", {31'd0, out_valid}, 32'd0);
        check("fullpop_ovf_end", {31'd0, overflow}, 32'd0);

        // Reset mid-drain with a tag still in flight.
        reset_pulse();
        for (int cyc = 0; cyc <= L + 2; cyc++) begin
            src_valid = (cyc < 2) || (cyc == L + 2);
            if (cyc >= L && cyc < L + 2) drive_blk(cyc - L);
            else drive_junk();
            out_ready = (cyc == L + 2);
            if (cyc == L + 2) check("mid_lane0", out_data, bv(0, 0));
            step();
        end
        src_valid = 1'b0; out_ready = 1'b0;
        check("mid_lane1", out_data, bv(0, 1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_valid", {31'd0, out_valid}, 32'd0);
        check("mid_data", out_data, 32'd0);
        check("mid_ovf", {31'd0, overflow}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < L + 3; i++) begin
            step();
            check("mid_no_stale", {31'd0, out_valid}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fir3x_drain.md
# fir3x_drain

Output stage placed directly downstream of the three-times-unrolled 16-tap FIR (`fir3x`). It tags which FIR output blocks carry valid data by delaying the producer's input-valid through the FIR's fixed latency. It captures each valid `y3k`/`y3k1`/`y3k2` triplet into a small block FIFO. It then serializes the triplets into a one-sample-per-cycle valid/ready stream in time order.

## Interface

Parameters:
- `LATENCY`, 6: cycles from a block being presented at the `fir3x` inputs to its result being present on `y3k..y3k2`; must be ≥ 1.
- `DEPTH`, 4: FIFO capacity in blocks (3 samples each); power of two, ≥ 2.
- `SHIFT`, 11: right-shift amount used only when scaling is compiled in (weight sum 2020 ≈ 2^11).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high; clears all state.
- `src_valid`  in  1: high in the cycle a valid block is driven onto the `fir3x` inputs.
- `y3k`  in  32: signed FIR output, oldest sample of the block.
- `y3k1`  in  32: signed FIR output, middle sample.
- `y3k2`  in  32: signed FIR output, newest sample.
- `out_data`  out  32: serialized sample, signed.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: consumer accepts `out_data` on a cycle where `out_valid && out_ready`.
- `overflow`  out  1: sticky flag; a valid block was dropped because the FIFO was full.

## Operation

- Tag pipe: `LATENCY`-bit shift register clocked every cycle, input `src_valid`. `tag` is the last stage, i.e. `src_valid` delayed by `LATENCY` cycles.
- Push: on an edge where `tag`=1, write {`y3k`,`y3k1`,`y3k2`} as one FIFO entry, if accepted.
- Acceptance rule: push is accepted if count < `DEPTH`, or if a pop occurs on the same edge.
- Rejected push: the block is discarded, `overflow` is set to 1, and `overflow` stays set until `reset`.
- FIFO: read and write pointers are log2(`DEPTH`)+1 bits, with wrap-around modulo `DEPTH`. Full when the pointers are equal except for the MSB; empty when the pointers are equal.
- Serializer: lane counter `lane` ∈ {0,1,2}, reset value 0.
  - `out_valid` = FIFO not empty.
  - `out_data` = head entry lane `lane` (0→`y3k`, 1→`y3k1`, 2→`y3k2`), after optional scaling.
  - Handshake with `lane`<2: `lane`+1.
  - Handshake with `lane`=2: `lane`←0 and pop the head entry.
- `out_data` must be held stable while `out_valid && !out_ready`.
- Ordering: blocks leave in arrival order, and samples leave `y3k`, `y3k1`, `y3k2` within a block.
- Sustained throughput: 1 block per 3 cycles. The producer must keep the long-run `src_valid` rate ≤ 1/3, otherwise blocks are dropped.

## Timing

- Reset values: `out_valid`=0, `overflow`=0, `out_data`=0 while empty; `lane`=0, pointers=0, all tag bits=0.
- `src_valid` high at cycle t → the y-triplet present during cycle t+`LATENCY` is written at the end of that cycle.
- `out_valid` rises in cycle t+`LATENCY`+1 (one cycle after the write edge).
- `out_data` and `out_valid` are combinational from registered FIFO/lane state; there is no combinational path from `out_ready` to `out_valid`.
- Reset mid-operation: the FIFO, the lane counter, in-flight tags and `overflow` are all cleared on the reset edge. No stale block emerges after reset deasserts.
- Reset dominates every simultaneous push or pop.

## Configuration

- Macro `FIR3X_DRAIN_SCALE_EN`.
- Defined: `out_data` = sat16((y + 2^(`SHIFT`-1)) >>> `SHIFT`), sign-extended to 32 bits.
  - Rounding is round-half-up, computed in 33-bit signed arithmetic.
  - sat16 clamps to [−32768, 32767].
- Undefined: `out_data` = raw 32-bit y sample, and `SHIFT` is unused.

## Test plan

- Reset: hold `reset` for 2 cycles with `src_valid`=1 → `out_valid`=0, `overflow`=0, no output for `LATENCY`+2 cycles after release with `src_valid`=0.
- Single block (raw): `src_valid`=1 at cycle 0 only; y=100/200/300 at cycle 6; `out_ready`=1 → `out_valid` in cycles 7–9 with `out_data` 100, 200, 300; `out_valid`=0 at cycle 10.
- Backpressure/overflow: `out_ready`=0, 5 valid blocks spaced 1 cycle apart → first 4 stored, 5th dropped, `overflow`=1. Raise `out_ready` → exactly 12 samples drain in order, and `overflow` stays 1.
- Full + simultaneous pop: FIFO full, `lane`=2 handshake on the same edge a tagged block arrives → block accepted, `overflow` stays 0, count stays `DEPTH`.
- Scaling (macro defined, `SHIFT`=11): y=2020000→986, y=1024→1, y=−1024→0, y=0x7FFFFFFF→32767, y=0x80000000→−32768 (0xFFFF8000).
- Reset mid-drain: 2 blocks queued, `lane`=1, assert `reset` 1 cycle → `out_valid`=0 next cycle. Tags issued before reset never produce output.
